// File: rtl/dtcm_pkg.sv
// Shared sizing constants and types for the DTCM responder and its storage array.
package dtcm_pkg;

    localparam int XLEN            = 32;
    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int DTCM_WORDS      = 2 ** (DTCM_ADDR_WIDTH - 2);
    localparam int RSP_DEPTH       = 2;

    // Tracks the access issued to the SRAM last cycle whose data lands this cycle.
    typedef struct packed {
        logic valid;
        logic is_read;
    } pipe_t;

endpackage

// File: rtl/dtcm_ram.sv
// Behavioural single-port SRAM with byte write enables and a one-cycle registered read.
// Kept port-compatible with the foundry macro so it can be swapped in directly.
module dtcm_ram
    import dtcm_pkg::*;
#(
    parameter int DATA_W  = XLEN,
    parameter int WORD_AW = DTCM_ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [WORD_AW-1:0]    addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2 ** WORD_AW];

    // Read data only changes on a read access, so it stays put across write cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// DTCM responder: accepts LSU commands, performs one SRAM access each, and returns
// in-order responses through a bypassable FIFO so back-pressure never drops data.
module dtcm_ctrl
    import dtcm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dtcm_cmd_valid,
    output logic                       dtcm_cmd_ready,
    input  logic                       dtcm_cmd_read,
    input  logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
    input  logic [XLEN-1:0]            dtcm_cmd_wdata,
    input  logic [XLEN/8-1:0]          dtcm_cmd_wmask,
    output logic                       dtcm_rsp_valid,
    input  logic                       dtcm_rsp_ready,
    output logic [XLEN-1:0]            dtcm_rsp_rdata
);

    localparam int WORD_AW = DTCM_ADDR_WIDTH - 2;
    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W   = $clog2(RSP_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [XLEN-1:0]  fifo_mem [RSP_DEPTH];
    logic [XLEN-1:0]  ram_rdata;
    logic [XLEN-1:0]  pipe_data;
    pipe_t            pipe;
    logic             accept;
    logic             retire;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^dtcm_cmd_addr[1:0];

    assign fifo_empty     = (fifo_count == '0);
    assign pipe_data      = (pipe.valid && pipe.is_read) ? ram_rdata : '0;
    assign dtcm_rsp_valid = !rst && (!fifo_empty || pipe.valid);
    assign dtcm_rsp_rdata = fifo_empty ? pipe_data : fifo_mem[rd_ptr];
    assign retire         = dtcm_rsp_valid && dtcm_rsp_ready;
    // A retire frees a slot in the same cycle, so full-rate streaming never stalls.
    assign dtcm_cmd_ready = !rst && ((count < DEPTH_C) || retire);
    assign accept         = dtcm_cmd_valid && dtcm_cmd_ready;
    assign push           = pipe.valid && !(fifo_empty && dtcm_rsp_ready);
    assign pop            = retire && !fifo_empty;

    dtcm_ram #(
        .DATA_W  (XLEN),
        .WORD_AW (WORD_AW)
    ) u_ram (
        .clk   (clk),
        .en    (accept),
        .we    (!dtcm_cmd_read),
        .be    (dtcm_cmd_wmask),
        .addr  (dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2]),
        .wdata (dtcm_cmd_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            pipe.valid   <= 1'b0;
            pipe.is_read <= 1'b0;
        end else begin
            unique case ({accept, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            pipe.valid   <= accept;
            pipe.is_read <= accept && dtcm_cmd_read;
        end
    end

    // An unconsumed pipe result is parked in the FIFO; the outstanding bound keeps it from overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pipe_data;
        end
    end

endmodule
